// File: rtl/reg_bank_write_if.sv
// rtl/reg_bank_write_if.sv - write-side bus of the 8-entry register file
//
// Purpose: groups the request inputs (WE, A2..A0, D, Clear) and the
//          registered outputs (Busy, WrAck, Q0..Q7) of reg_bank_write.
// Modports:
//   master : requester side, drives WE/A2/A1/A0/D/Clear, observes outputs
//   slave  : register bank side, receives requests, drives Busy/WrAck/Q0..Q7
interface reg_bank_write_if #(
    parameter int WIDTH = 13
);
    logic             WE;
    logic             A2;
    logic             A1;
    logic             A0;
    logic [WIDTH-1:0] D;
    logic             Clear;
    logic             Busy;
    logic             WrAck;
    logic [WIDTH-1:0] Q0;
    logic [WIDTH-1:0] Q1;
    logic [WIDTH-1:0] Q2;
    logic [WIDTH-1:0] Q3;
    logic [WIDTH-1:0] Q4;
    logic [WIDTH-1:0] Q5;
    logic [WIDTH-1:0] Q6;
    logic [WIDTH-1:0] Q7;

    modport master (
        output WE, A2, A1, A0, D, Clear,
        input  Busy, WrAck, Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7
    );

    modport slave (
        input  WE, A2, A1, A0, D, Clear,
        output Busy, WrAck, Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7
    );
endinterface

// File: rtl/reg_bank_write.sv
// rtl/reg_bank_write.sv - write side of the 8 x WIDTH register file with sequential clear
//
// Purpose: decodes {A2,A1,A0} into a one-hot entry enable, stores D with a
//          one-cycle WrAck, and runs an 8-cycle clear sweep on request.
// Ports:
//   Clock : rising-edge clock for all state
//   Reset : synchronous, active-high, overrides everything
//   bus   : reg_bank_write_if.slave (WE, A2..A0, D, Clear in;
//           Busy, WrAck, Q0..Q7 out, all registered)
module reg_bank_write #(
    parameter int               WIDTH     = 13,
    parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
    input  logic              Clock,
    input  logic              Reset,
    reg_bank_write_if.slave   bus
);
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state;
    logic [2:0]       cnt;
    logic             busy;
    logic             wrack;
    logic [WIDTH-1:0] q [8];
    logic [2:0]       addr;

    assign addr = {bus.A2, bus.A1, bus.A0};

    always_ff @(posedge Clock) begin
        if (Reset) begin
            // Reset zeroes the entries regardless of CLR_VALUE and abandons any sweep.
            for (int i = 0; i < 8; i++) begin
                q[i] <= '0;
            end
            state <= IDLE;
            cnt   <= 3'd0;
            busy  <= 1'b0;
            wrack <= 1'b0;
        end else begin
            wrack <= 1'b0;
            case (state)
                IDLE: begin
                    // Clear takes precedence; a simultaneous write is dropped.
                    if (bus.Clear) begin
                        state <= CLEAR;
                        cnt   <= 3'd0;
                        busy  <= 1'b1;
                    end else if (bus.WE) begin
                        q[addr] <= bus.D;
                        wrack   <= 1'b1;
                    end
                end
                CLEAR: begin
                    // WE and Clear are ignored here; one entry is cleared per cycle.
                    q[cnt] <= CLR_VALUE;
                    cnt    <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Busy  = busy;
    assign bus.WrAck = wrack;
    assign bus.Q0    = q[0];
    assign bus.Q1    = q[1];
    assign bus.Q2    = q[2];
    assign bus.Q3    = q[3];
    assign bus.Q4    = q[4];
    assign bus.Q5    = q[5];
    assign bus.Q6    = q[6];
    assign bus.Q7    = q[7];
endmodule

// File: tb/tb_reg_bank_write.sv
// tb/tb_reg_bank_write.sv - directed self-checking bench for reg_bank_write
module tb_reg_bank_write;
    logic Clock;
    logic Reset;
    int   total;
    int   bad;

    reg_bank_write_if #(.WIDTH(13)) bus ();

    reg_bank_write #(.WIDTH(13), .CLR_VALUE(13'd0)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic [12:0] q [8];
    assign q[0] = bus.Q0;
    assign q[1] = bus.Q1;
    assign q[2] = bus.Q2;
    assign q[3] = bus.Q3;
    assign q[4] = bus.Q4;
    assign q[5] = bus.Q5;
    assign q[6] = bus.Q6;
    assign q[7] = bus.Q7;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int n);
        bus.A2 = n[2];
        bus.A1 = n[1];
        bus.A0 = n[0];
    endtask

    task automatic fill_all(input logic [12:0] v);
        for (int n = 0; n < 8; n++) begin
            set_addr(n);
            bus.D  = v;
            bus.WE = 1'b1;
            tick();
        end
        bus.WE = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // 1: reset with a write request held
        Reset     = 1'b1;
        bus.WE    = 1'b1;
        bus.D     = 13'h1FFF;
        bus.Clear = 1'b0;
        set_addr(7);
        tick();
        for (int n = 0; n < 8; n++) chk($sformatf("reset_q%0d", n), q[n], 13'h0000);
        chk("reset_busy", {12'd0, bus.Busy}, 13'd0);
        chk("reset_wrack", {12'd0, bus.WrAck}, 13'd0);
        Reset  = 1'b0;
        bus.WE = 1'b0;
        tick();
        chk("idle_wrack", {12'd0, bus.WrAck}, 13'd0);

        // 2: single write to address 5
        set_addr(5);
        bus.D  = 13'h0ABC;
        bus.WE = 1'b1;
        tick();
        bus.WE = 1'b0;
        chk("w5_q5", q[5], 13'h0ABC);
        chk("w5_wrack", {12'd0, bus.WrAck}, 13'd1);
        for (int n = 0; n < 8; n++) if (n != 5) chk($sformatf("w5_other_q%0d", n), q[n], 13'h0000);
        tick();
        chk("w5_wrack_drop", {12'd0, bus.WrAck}, 13'd0);
        chk("w5_q5_hold", q[5], 13'h0ABC);

        // 3: eight back-to-back writes
        for (int n = 0; n < 8; n++) begin
            set_addr(n);
            bus.D  = 13'h100 + 13'(n);
            bus.WE = 1'b1;
            tick();
            chk($sformatf("b2b_wrack%0d", n), {12'd0, bus.WrAck}, 13'd1);
            chk($sformatf("b2b_q%0d", n), q[n], 13'h100 + 13'(n));
        end
        bus.WE = 1'b0;
        tick();
        chk("b2b_wrack_end", {12'd0, bus.WrAck}, 13'd0);
        for (int n = 0; n < 8; n++) chk($sformatf("b2b_hold_q%0d", n), q[n], 13'h100 + 13'(n));

        // same address on consecutive cycles: last value wins
        set_addr(1);
        bus.D  = 13'h0011;
        bus.WE = 1'b1;
        tick();
        bus.D  = 13'h0022;
        tick();
        bus.WE = 1'b0;
        chk("same_addr_q1", q[1], 13'h0022);

        // 4: fill with 1FFF then sweep; a mid-sweep Clear must not restart it
        fill_all(13'h1FFF);
        bus.Clear = 1'b1;
        tick();
        bus.Clear = 1'b0;
        chk("clr_busy_start", {12'd0, bus.Busy}, 13'd1);
        chk("clr_q0_before", q[0], 13'h1FFF);
        for (int i = 0; i < 8; i++) begin
            bus.Clear = (i == 2);
            tick();
            chk($sformatf("clr_q%0d_zero", i), q[i], 13'h0000);
            if (i < 7) chk($sformatf("clr_q%0d_pending", i + 1), q[i + 1], 13'h1FFF);
            chk($sformatf("clr_busy%0d", i), {12'd0, bus.Busy}, (i < 7) ? 13'd1 : 13'd0);
        end
        bus.Clear = 1'b0;
        tick();
        chk("clr_busy_after", {12'd0, bus.Busy}, 13'd0);

        // 5: Clear beats a simultaneous write; write in the last Busy cycle is dropped
        set_addr(2);
        bus.D     = 13'h0055;
        bus.WE    = 1'b1;
        bus.Clear = 1'b1;
        tick();
        bus.WE    = 1'b0;
        bus.Clear = 1'b0;
        chk("cw_wrack", {12'd0, bus.WrAck}, 13'd0);
        chk("cw_busy", {12'd0, bus.Busy}, 13'd1);
        chk("cw_q2", q[2], 13'h0000);
        for (int i = 0; i < 7; i++) tick();
        chk("cw_busy_last", {12'd0, bus.Busy}, 13'd1);
        set_addr(3);
        bus.D  = 13'h0333;
        bus.WE = 1'b1;
        tick();
        bus.WE = 1'b0;
        chk("busy_we_wrack", {12'd0, bus.WrAck}, 13'd0);
        chk("busy_we_q3", q[3], 13'h0000);
        chk("cw_q2_after", q[2], 13'h0000);
        chk("cw_busy_end", {12'd0, bus.Busy}, 13'd0);

        // 6: reset in the 4th clear cycle
        fill_all(13'h1FFF);
        bus.Clear = 1'b1;
        tick();
        bus.Clear = 1'b0;
        tick();
        tick();
        tick();
        for (int n = 0; n < 3; n++) chk($sformatf("mid_q%0d", n), q[n], 13'h0000);
        for (int n = 4; n < 8; n++) chk($sformatf("mid_q%0d", n), q[n], 13'h1FFF);
        chk("mid_busy", {12'd0, bus.Busy}, 13'd1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        for (int n = 0; n < 8; n++) chk($sformatf("rst_mid_q%0d", n), q[n], 13'h0000);
        chk("rst_mid_busy", {12'd0, bus.Busy}, 13'd0);
        set_addr(6);
        bus.D  = 13'h0777;
        bus.WE = 1'b1;
        tick();
        bus.WE = 1'b0;
        chk("post_rst_q6", q[6], 13'h0777);
        chk("post_rst_wrack", {12'd0, bus.WrAck}, 13'd1);
        chk("post_rst_busy", {12'd0, bus.Busy}, 13'd0);
        tick();
        chk("post_rst_q7", q[7], 13'h0000);
        chk("post_rst_busy2", {12'd0, bus.Busy}, 13'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
